// File: rtl/sap_datapath.sv
// SAP-1 style 8-bit datapath: PC, MAR, 16x8 RAM, IR, A, B, OUT around a prioritised W bus.
// Optional build macro SAP_FLAGS_EN adds registered carry/zero flags and their ports.
module sap_datapath (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] control_word,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  instruction,
  output logic [7:0]  out_value,
  output logic        bus_conflict
`ifdef SAP_FLAGS_EN
  ,
  output logic        carry,
  output logic        zero
`endif
);

  typedef struct packed {
    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
  } ctrl_t;

  ctrl_t ctrl;
  assign ctrl = ctrl_t'(control_word);

  logic [3:0] pc_q, pc_d, mar_q, mar_d;
  logic [7:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic [7:0] mem [16];
  logic [7:0] bus, b_op, alu_result;
  logic [2:0] n_drivers;

  // Subtraction is A + ~B + 1; the +1 comes in as the carry-in.
  assign b_op = ctrl.su ? ~b_q : b_q;
`ifdef SAP_FLAGS_EN
  logic alu_carry;
  assign {alu_carry, alu_result} = {1'b0, a_q} + {1'b0, b_op} + 9'(ctrl.su);
`else
  assign alu_result = a_q + b_op + 8'(ctrl.su);
`endif

  assign n_drivers = 3'(ctrl.ep) + 3'(!ctrl.ce_n) + 3'(!ctrl.ei_n) + 3'(ctrl.ea) + 3'(ctrl.eu);
  assign bus_conflict = (n_drivers >= 3'd2);

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    bus = 8'h00;
    if (ctrl.ep)          bus = {4'h0, pc_q};
    else if (!ctrl.ce_n)  bus = mem[mar_q];
    else if (!ctrl.ei_n)  bus = {4'h0, ir_q[3:0]};
    else if (ctrl.ea)     bus = a_q;
    else if (ctrl.eu)     bus = alu_result;
  end

  always_comb begin
    pc_d  = ctrl.cp    ? pc_q + 4'd1 : pc_q;
    mar_d = !ctrl.lm_n ? bus[3:0]    : mar_q;
    ir_d  = !ctrl.li_n ? bus         : ir_q;
    a_d   = !ctrl.la_n ? bus         : a_q;
    b_d   = !ctrl.lb_n ? bus         : b_q;
    out_d = !ctrl.lo_n ? bus         : out_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge bus.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
    end
  end

  // NOTE: the program RAM has no reset, so a loaded program survives reset_n.
  always_ff @(posedge clock) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

`ifdef SAP_FLAGS_EN
  logic carry_q, zero_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (!ctrl.la_n && ctrl.eu) begin
      carry_q <= alu_carry;
      zero_q  <= (alu_result == 8'h00);
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

  assign instruction = ir_q[7:4];
  assign out_value   = out_q;

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: expected OUT/opcode values queued per control step, checked after the edge.
module tb_sap_datapath;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] control_word;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [3:0]  instruction;
  logic [7:0]  out_value;
  logic        bus_conflict;
`ifdef SAP_FLAGS_EN
  logic        carry, zero;
`endif

  sap_datapath dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .control_word (control_word),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .instruction  (instruction),
    .out_value    (out_value),
    .bus_conflict (bus_conflict)
`ifdef SAP_FLAGS_EN
    ,
    .carry        (carry),
    .zero         (zero)
`endif
  );

  always #5 clock = ~clock;

  // Each field toggled from NOP becomes active, whatever its polarity.
  localparam logic [11:0] NOP = 12'b0011_1110_0011;
  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  function automatic logic [11:0] cw(input logic [11:0] on);
    return NOP ^ on;
  endfunction

  typedef enum logic {SIG_OUT, SIG_INSTR} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] v);
    sb_q.push_back('{tag, SIG_OUT, v});
  endtask

  task automatic expect_instr(input string tag, input logic [3:0] v);
    sb_q.push_back('{tag, SIG_INSTR, {4'h0, v}});
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, (e.sig == SIG_OUT) ? out_value : {4'h0, instruction}, e.exp);
    end
  endtask

  task automatic pstep(input logic [11:0] c, input logic we, input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    control_word = c;
    prog_we      = we;
    prog_addr    = a;
    prog_data    = d;
    @(posedge clock);
    #1;
    prog_we = 1'b0;
    drain();
  endtask

  task automatic step(input logic [11:0] c);
    pstep(c, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clock);
    control_word = NOP;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic cp_n(input int n);
    for (int i = 0; i < n; i++) step(cw(CP));
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    step(cw(EP | LM));
    step(cw(CP));
    expect_instr(tag, op);
    step(cw(CE | LI));
  endtask

  logic [3:0] prog_a [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11};
  logic [7:0] prog_d [8] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h10, 8'h14, 8'h0E};

  initial begin
    control_word = NOP;
    #7;
    check("reset_out", out_value, 8'h00);
    check("reset_instr", {4'h0, instruction}, 8'h00);
    check("nop_no_conflict", {7'h0, bus_conflict}, 8'h00);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) pstep(NOP, 1'b1, prog_a[i], prog_d[i]);
    pstep(NOP, 1'b1, 4'd12, 8'h77);
    expect_out("nop_hold", 8'h00);
    step(NOP);

    // LDA 9 / ADD 10 / SUB 11 / OUT / HLT
    fetch("fetch_lda", 4'h0);
    step(cw(EI | LM)); step(cw(CE | LA)); step(NOP);
    fetch("fetch_add", 4'h1);
    step(cw(EI | LM)); step(cw(CE | LB)); step(cw(EU | LA));
    fetch("fetch_sub", 4'h2);
    step(cw(EI | LM)); step(cw(CE | LB)); step(cw(EU | LA | SU));
    fetch("fetch_out", 4'hE);
    expect_out("prog_out", 8'h16);
    step(cw(EA | LO));
    fetch("fetch_hlt", 4'hF);
    expect_out("prog_out_hold", 8'h16);
    step(NOP);

    // PC wraps modulo 16
    do_reset();
    cp_n(5);
    expect_out("pc_five", 8'h05);
    step(cw(EP | LO));
    cp_n(11);
    expect_out("pc_wrap", 8'h00);
    step(cw(EP | LO));
    step(cw(EP | LM));
    expect_out("mar_after_wrap", 8'h09);
    step(cw(CE | LO));

    // Two drivers: Ep wins over Ea
    do_reset();
    cp_n(12);
    step(cw(EP | LM));
    step(cw(CE | LA));
    cp_n(9);
    @(negedge clock);
    control_word = cw(EP | EA | LB);
    #1 check("conflict_flag", {7'h0, bus_conflict}, 8'h01);
    @(posedge clock);
    #1;
    expect_out("conflict_b_05", 8'h7C);
    step(cw(EU | LO));
    check("conflict_clear", {7'h0, bus_conflict}, 8'h00);

    // Program write to the address being read: bus sees old data
    do_reset();
    cp_n(9);
    step(cw(EP | LM));
    expect_instr("wr_read_old", 4'h1);
    pstep(cw(CE | LI), 1'b1, 4'd9, 8'h55);
    expect_out("wr_new_data", 8'h55);
    step(cw(CE | LO));

    // Asynchronous reset mid-instruction
    pstep(NOP, 1'b1, 4'd9, 8'h3C);
    step(cw(CE | LA));
    expect_instr("pre_rst_ir", 4'h3);
    step(cw(CE | LI));
    expect_out("pre_rst_a", 8'h3C);
    step(cw(EA | LO));
    @(negedge clock);
    control_word = NOP;
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_out", out_value, 8'h00);
    check("async_rst_instr", {4'h0, instruction}, 8'h00);
    #1 reset_n = 1'b1;
    expect_out("rst_a_b_zero", 8'h00);
    step(cw(EU | LO));
    cp_n(9);
    step(cw(EP | LM));
    expect_out("ram_kept", 8'h3C);
    step(cw(CE | LO));

`ifdef SAP_FLAGS_EN
    pstep(NOP, 1'b1, 4'd12, 8'hF0);
    pstep(NOP, 1'b1, 4'd13, 8'h20);
    pstep(NOP, 1'b1, 4'd14, 8'h14);
    do_reset();
    cp_n(12);
    step(cw(EP | LM)); step(cw(CE | LA));
    step(cw(CP));
    step(cw(EP | LM)); step(cw(CE | LB));
    step(cw(EU | LA));
    check("add_carry", {7'h0, carry}, 8'h01);
    check("add_zero", {7'h0, zero}, 8'h00);
    expect_out("add_result", 8'h10);
    step(cw(EA | LO));
    step(cw(CP));
    step(cw(EP | LM)); step(cw(CE | LA)); step(cw(CE | LB));
    step(cw(EU | LA | SU));
    check("sub_carry", {7'h0, carry}, 8'h01);
    check("sub_zero", {7'h0, zero}, 8'h01);
    expect_out("sub_result", 8'h00);
    step(cw(EA | LO));
    step(cw(EU));
    check("flags_held", {6'h0, carry, zero}, 8'h03);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
